// File: rtl/logic_arbiter.sv
// -----------------------------------------------------------------------------
// logic_arbiter
//   Four-requester arbiter in front of a single bitwise logic unit
//   (AND / OR / XOR / NOR). One operation is in flight at a time:
//   IDLE grants and captures, EXEC computes, VALID holds the result until
//   the consumer takes it.
//
//   Build option:
//     LOGIC_ARB_ROUND_ROBIN_EN  defined   -> round-robin selection with a
//                                            last-grant pointer (reset 3)
//                               undefined -> fixed priority, lowest index wins
//
// Ports
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   req        in   [3:0] per-requester request
//   a_bus      in   [4N-1:0] operand A, requester i at [i*N +: N]
//   b_bus      in   [4N-1:0] operand B, same packing
//   op_bus     in   [7:0] opcode, requester i at [2i +: 2]
//                   00=AND 01=OR 10=XOR 11=NOR
//   gnt        out  [3:0] one-hot accept strobe (IDLE only)
//   busy       out  state != IDLE
//   out_valid  out  result available
//   out_id     out  [1:0] owner of result
//   result     out  [N-1:0] bitwise result
//   out_ready  in   consumer accepts result (ignored outside VALID)
//   op_count   out  [15:0] completed-operation counter, wraps
// -----------------------------------------------------------------------------
module logic_arbiter #(
    parameter int N = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [3:0]     req,
    input  logic [4*N-1:0] a_bus,
    input  logic [4*N-1:0] b_bus,
    input  logic [7:0]     op_bus,
    output logic [3:0]     gnt,
    output logic           busy,
    output logic           out_valid,
    output logic [1:0]     out_id,
    output logic [N-1:0]   result,
    input  logic           out_ready,
    output logic [15:0]    op_count
);

    typedef enum logic [1:0] {IDLE, EXEC, VALID} state_t;

    state_t         r_state;
    logic [N-1:0]   r_a;
    logic [N-1:0]   r_b;
    logic [1:0]     r_op;
    logic [1:0]     r_id;
    logic [N-1:0]   r_result;
    logic [1:0]     r_out_id;
    logic           r_out_valid;
    logic [15:0]    r_op_count;

    logic [1:0]     w_sel;
    logic           w_any;
    logic           w_take;
    logic [N-1:0]   w_result;

`ifdef LOGIC_ARB_ROUND_ROBIN_EN
    logic [1:0] r_ptr;

    // Walk the candidates from farthest to nearest after the pointer so the
    // last assignment is the closest requester above the last grant.
    always_comb begin
        w_sel = r_ptr;
        w_any = 1'b0;
        for (int k = 4; k >= 1; k--) begin
            if (req[2'(int'(r_ptr) + k)]) begin
                w_sel = 2'(int'(r_ptr) + k);
                w_any = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_ptr <= 2'd3;
        else if (w_take)
            r_ptr <= w_sel;
    end
`else
    // Descending scan: the lowest set index is written last and wins.
    always_comb begin
        w_sel = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (req[k])
                w_sel = 2'(k);
        end
        w_any = |req;
    end
`endif

    assign w_take = (r_state == IDLE) && w_any;

    // gnt is gated by rst_n so it reads zero for the whole reset window.
    always_comb begin
        gnt = 4'b0000;
        if (rst_n && w_take)
            gnt[w_sel] = 1'b1;
    end

    always_comb begin
        case (r_op)
            2'b00:   w_result = r_a & r_b;
            2'b01:   w_result = r_a | r_b;
            2'b10:   w_result = r_a ^ r_b;
            default: w_result = ~(r_a | r_b);
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_op        <= 2'd0;
            r_id        <= 2'd0;
            r_result    <= '0;
            r_out_id    <= 2'd0;
            r_out_valid <= 1'b0;
            r_op_count  <= 16'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_a     <= a_bus[int'(w_sel)*N +: N];
                        r_b     <= b_bus[int'(w_sel)*N +: N];
                        r_op    <= op_bus[int'(w_sel)*2 +: 2];
                        r_id    <= w_sel;
                        r_state <= EXEC;
                    end
                end
                EXEC: begin
                    r_result    <= w_result;
                    r_out_id    <= r_id;
                    r_out_valid <= 1'b1;
                    r_state     <= VALID;
                end
                VALID: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_op_count  <= r_op_count + 16'd1;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy      = (r_state != IDLE);
    assign out_valid = r_out_valid;
    assign out_id    = r_out_id;
    assign result    = r_result;
    assign op_count  = r_op_count;

endmodule

// File: tb/tb_logic_arbiter.sv
// -----------------------------------------------------------------------------
// tb_logic_arbiter
//   Scoreboard bench. The stimulus side predicts each grant from a
//   transaction-level model (request set + last grant), pushes the expected
//   {owner, result} at grant time, and checks gnt/busy/out_valid per cycle.
//   An independent monitor compares result/out_id/op_count whenever the DUT
//   presents a valid result.
// -----------------------------------------------------------------------------
module tb_logic_arbiter;
    localparam int N = 32;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [3:0]     req;
    logic [4*N-1:0] a_bus;
    logic [4*N-1:0] b_bus;
    logic [7:0]     op_bus;
    logic           out_ready;
    logic [3:0]     gnt;
    logic           busy;
    logic           out_valid;
    logic [1:0]     out_id;
    logic [N-1:0]   result;
    logic [15:0]    op_count;

    logic_arbiter #(.N(N)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .a_bus(a_bus), .b_bus(b_bus),
        .op_bus(op_bus), .gnt(gnt), .busy(busy), .out_valid(out_valid),
        .out_id(out_id), .result(result), .out_ready(out_ready),
        .op_count(op_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]   id;
        logic [N-1:0] res;
    } exp_t;

    exp_t        q[$];
    int          n_checks = 0;
    int          n_errs   = 0;
    int          m_stage;      // 0 idle, 1 computing, 2 holding result
    int          m_last;       // last granted index (round-robin only)
    int          m_gidx;
    logic [15:0] mon_count;

    function automatic logic [N-1:0] ref_op(logic [1:0] op, logic [N-1:0] a, logic [N-1:0] b);
        case (op)
            2'd0:    return a & b;
            2'd1:    return a | b;
            2'd2:    return a ^ b;
            default: return ~(a | b);
        endcase
    endfunction

    function automatic int pick(logic [3:0] r);
`ifdef LOGIC_ARB_ROUND_ROBIN_EN
        for (int k = 1; k <= 4; k++)
            if (r[(m_last + k) % 4]) return (m_last + k) % 4;
`else
        for (int i = 0; i < 4; i++)
            if (r[i]) return i;
`endif
        return -1;
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s got=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic set_req(int i, logic [N-1:0] a, logic [N-1:0] b, logic [1:0] op);
        a_bus[i*N +: N] = a;
        b_bus[i*N +: N] = b;
        op_bus[i*2 +: 2] = op;
        req[i] = 1'b1;
    endtask

    // One clock: inputs are already driven; check at negedge, advance the
    // model after the rising edge using the values that edge saw.
    task automatic step();
        logic [3:0] eg;
        m_gidx = (m_stage == 0) ? pick(req) : -1;
        eg = (m_gidx >= 0) ? 4'(1 << m_gidx) : 4'b0000;
        @(negedge clk);
        chk("gnt", 64'(gnt), 64'(eg));
        chk("busy", 64'(busy), 64'(m_stage != 0));
        chk("out_valid", 64'(out_valid), 64'(m_stage == 2));
        @(posedge clk);
        #1;
        if (m_gidx >= 0) begin
            q.push_back('{id: 2'(m_gidx),
                          res: ref_op(op_bus[m_gidx*2 +: 2], a_bus[m_gidx*N +: N], b_bus[m_gidx*N +: N])});
            req[m_gidx] = 1'b0;
            m_last  = m_gidx;
            m_stage = 1;
        end else if (m_stage == 1) begin
            m_stage = 2;
        end else if (m_stage == 2 && out_ready) begin
            m_stage = 0;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = 4'hF;
        #1;
        chk("rst_gnt", 64'(gnt), 0);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_out_valid", 64'(out_valid), 0);
        chk("rst_result", 64'(result), 0);
        chk("rst_out_id", 64'(out_id), 0);
        chk("rst_op_count", 64'(op_count), 0);
        m_stage = 0;
        m_last  = 3;
        q.delete();
        mon_count = 16'd0;
        @(negedge clk);
        chk("rst_gnt_hold", 64'(gnt), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        req   = 4'h0;
    endtask

    // Monitor: every cycle a result is presented it must match the oldest
    // outstanding grant; on acceptance the counter must equal results so far.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && out_valid === 1'b1) begin
                if (q.size() == 0) begin
                    n_checks++;
                    n_errs++;
                    $display("FAIL unexpected_valid got=1 expected=0 at %0t", $time);
                end else begin
                    chk("result", 64'(result), 64'(q[0].res));
                    chk("out_id", 64'(out_id), 64'(q[0].id));
                    if (out_ready) begin
                        chk("op_count", 64'(op_count), 64'(mon_count));
                        void'(q.pop_front());
                        mon_count = mon_count + 16'd1;
                    end
                end
            end
        end
    end

    initial begin
        rst_n = 1'b1; req = 4'h0; a_bus = '0; b_bus = '0; op_bus = '0; out_ready = 1'b0;
        m_stage = 0; m_last = 3; m_gidx = -1; mon_count = 16'd0;
        #1;
        do_reset();

        // single AND op with exact latency
        out_ready = 1'b1;
        set_req(0, 32'hF0F0_F0F0, 32'hFF00_FF00, 2'b00);
        repeat (4) step();
        chk("single_op_count", 64'(op_count), 1);

        // remaining opcodes
        for (int op = 1; op < 4; op++) begin
            set_req(1, 32'hAAAA_AAAA, 32'hFFFF_0000, 2'(op));
            repeat (3) step();
        end

        // backpressure with a competing request pending
        set_req(0, $urandom, $urandom, 2'($urandom_range(0, 3)));
        step(); step();
        out_ready = 1'b0;
        set_req(1, $urandom, $urandom, 2'($urandom_range(0, 3)));
        repeat (5) step();
        out_ready = 1'b1;
        repeat (4) step();

        // contention: all four held high
        for (int i = 0; i < 4; i++) set_req(i, $urandom, $urandom, 2'(i));
        repeat (15) begin
            req = 4'hF;
            step();
        end
        req = 4'h0;
        repeat (3) step();

        // reset while computing
        set_req(3, $urandom, $urandom, 2'b10);
        step();
        do_reset();
        set_req(2, 32'h1234_5678, 32'h0F0F_0F0F, 2'b01);
        repeat (4) step();

        // randomized traffic
        repeat (3000) begin
            for (int i = 0; i < 4; i++)
                if (!req[i] && $urandom_range(0, 2) == 0)
                    set_req(i, $urandom, $urandom, 2'($urandom_range(0, 3)));
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        req = 4'h0;
        out_ready = 1'b1;
        repeat (4) step();

        // counter wrap from 0xFFFF
        force dut.r_op_count = 16'hFFFF;
        #1;
        release dut.r_op_count;
        mon_count = 16'hFFFF;
        set_req(1, $urandom, $urandom, 2'b11);
        repeat (4) step();
        chk("op_count_wrap", 64'(op_count), 0);
        chk("queue_empty", 64'(q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
        $finish;
    end

endmodule

// File: doc/logic_arbiter.md
LOGIC_ARBITER -- requirements
Module: logic_arbiter

Interface
REQ-001 Parameter N SHALL default to 32 and set the operand/result width.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req  input  4  per-requester operation request; bit i is requester i.
REQ-005 a_bus  input  4*N  operand A; requester i occupies bits [i*N+N-1 : i*N].
REQ-006 b_bus  input  4*N  operand B; same packing as a_bus.
REQ-007 op_bus  input  8  opcode; requester i occupies bits [2i+1 : 2i]; 00=AND, 01=OR, 10=XOR, 11=NOR.
REQ-008 gnt  output  4  one-hot accept strobe to the selected requester.
REQ-009 busy  output  1  high whenever state is not IDLE.
REQ-010 out_valid  output  1  result available.
REQ-011 out_id  output  2  index of the requester that owns result.
REQ-012 result  output  N  bitwise result.
REQ-013 out_ready  input  1  consumer accepts result.
REQ-014 op_count  output  16  completed-operation counter.

Function
REQ-015 FSM states SHALL be IDLE, EXEC and VALID.
REQ-016 In IDLE with req != 0, gnt SHALL combinationally assert one-hot for the selected requester; otherwise gnt = 0.
REQ-017 gnt SHALL be 0 in EXEC and VALID.
REQ-018 On the edge where gnt is high, the block SHALL capture that requester's A, B, opcode and index, then go to EXEC.
REQ-019 Requesters SHALL hold req, operands and opcode stable until they see gnt; the block ignores deassertion after capture.
REQ-020 In EXEC the block SHALL register the bitwise op of the captured operands into result, set out_id, and go to VALID next edge.
REQ-021 The AND path SHALL be a per-bit 2-input AND; OR, XOR and NOR SHALL be per-bit on the same operands.
REQ-022 In VALID, out_valid SHALL be 1, with result and out_id stable until the edge where out_ready = 1.
REQ-023 On that edge the FSM SHALL return to IDLE and op_count SHALL increment by 1, wrapping from 0xFFFF to 0x0000.
REQ-024 Minimum spacing between consecutive grants SHALL be 3 cycles (IDLE, EXEC, VALID with out_ready high); results remain in order.
REQ-025 out_ready while not in VALID SHALL have no effect.

Reset
REQ-026 rst_n low SHALL immediately force: state=IDLE, result=0, out_id=0, out_valid=0, op_count=0, and round-robin pointer=3.
REQ-027 While rst_n is low, gnt=0 and busy=0.
REQ-028 Reset mid-operation SHALL discard the in-flight operation without incrementing op_count.
REQ-029 Requests SHALL be arbitrated normally from the first rising edge after rst_n deasserts.

Configuration
REQ-030 With macro LOGIC_ARB_ROUND_ROBIN_EN defined, selection SHALL be round-robin: search from pointer+1 upward modulo 4, and update pointer to the granted index on each grant.
REQ-031 Without LOGIC_ARB_ROUND_ROBIN_EN, selection SHALL be fixed priority (lowest index wins), with no pointer register.

Verification
REQ-032 Single op: req=0001, A0=0xF0F0_F0F0, B0=0xFF00_FF00, op0=00, out_ready=1 -> gnt=0001 in cycle 0, out_valid in cycle 2, result=0xF000_F000, out_id=0, op_count=1.
REQ-033 Opcodes: A=0xAAAA_AAAA, B=0xFFFF_0000 through ops 01/10/11 -> results 0xFFFF_AAAA / 0x5555_AAAA / 0x0000_5555.
REQ-034 Backpressure: out_ready=0 for 5 cycles in VALID -> out_valid, result and out_id stable; gnt=0 despite pending req; FSM exits one edge after out_ready=1.
REQ-035 Contention: req=1111 held continuously, out_ready=1 -> with LOGIC_ARB_ROUND_ROBIN_EN grant order is 0,1,2,3,0; without it, requester 0 is granted every time.
REQ-036 Reset mid-EXEC: rst_n low for 1 cycle -> all outputs 0, op_count unchanged at 0, next req=0100 is granted to requester 2.
REQ-037 Wrap: preload op_count to 0xFFFF via 65535 ops, then one more accepted result -> op_count=0x0000.
